// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and arithmetic helpers for the time-multiplexed FIR
package fir_pkg;

  localparam int RS_ACC_W = 128;
  localparam int RS_VAL_W = 64;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;

  typedef struct packed {
    logic                sat;
    logic [RS_VAL_W-1:0] val;
  } round_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int dw, input int cw, input int depth);
    return dw + cw + clog2(depth);
  endfunction

  // Round half up, then clamp to a dw-bit signed range; sat flags a clamp.
  function automatic round_t round_sat(input logic signed [RS_ACC_W-1:0] acc,
                                       input int frac, input int dw);
    logic signed [RS_ACC_W-1:0] one, r, hi, lo;
    round_t res;
    one = RS_ACC_W'(1);
    r   = (acc + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    res.sat = 1'b0;
    res.val = r[RS_VAL_W-1:0];
    if (r > hi) begin
      res.val = hi[RS_VAL_W-1:0];
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo[RS_VAL_W-1:0];
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mc_serial_if.sv
// rtl/fir_mc_serial_if.sv - sample-in and sample-out handshake bundle
interface fir_mc_serial_if #(
  parameter int DATA_WIDTH = 24,
  parameter int CH_W       = 1
);
  logic [DATA_WIDTH-1:0] iv_din;
  logic [CH_W-1:0]       iv_din_ch;
  logic                  i_din_valid;
  logic                  o_din_ready;
  logic [DATA_WIDTH-1:0] ov_dout;
  logic [CH_W-1:0]       ov_dout_ch;
  logic                  o_dout_valid;
  logic                  i_dout_ready;

  modport master (
    output iv_din, iv_din_ch, i_din_valid, i_dout_ready,
    input  o_din_ready, ov_dout, ov_dout_ch, o_dout_valid
  );

  modport slave (
    input  iv_din, iv_din_ch, i_din_valid, i_dout_ready,
    output o_din_ready, ov_dout, ov_dout_ch, o_dout_valid
  );
endinterface

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - registered multiplier feeding an accumulator, shared by all channels
module fir_mac
  import fir_pkg::*;
#(
  parameter int A_W   = 24,
  parameter int B_W   = 24,
  parameter int ACC_W = 53
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    mul_ld,
  input  logic                    acc_add,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      acc  <= '0;
    end else if (en) begin
      if (clr) begin
        prod <= '0;
        acc  <= '0;
      end else begin
        if (mul_ld)  prod <= a * b;
        if (acc_add) acc  <= acc + ACC_W'(prod);
      end
    end
  end
endmodule

// File: rtl/fir_mc_serial.sv
// rtl/fir_mc_serial.sv - multi-channel FIR sharing one MAC across per-channel delay lines
module fir_mc_serial
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 24,
  parameter int COEF_FRAC  = 23,
  parameter int FIR_DEPTH  = 32,
  parameter int NUM_CH     = 2,
  localparam int CH_W      = ch_w(NUM_CH),
  localparam int AW        = clog2(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  fir_mc_serial_if.slave        bus,
  input  logic [AW-1:0]         iv_coef_addr,
  input  logic [COEF_WIDTH-1:0] iv_coef_data,
  input  logic                  i_coef_we,
  input  logic                  i_sat_clr,
  output logic                  o_sat,
  output logic                  o_busy
);
  localparam int ACC_W = acc_w(DATA_WIDTH, COEF_WIDTH, FIR_DEPTH);
  localparam int CNT_W = clog2(FIR_DEPTH + 1);

  fir_state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] line [NUM_CH][FIR_DEPTH];
  logic signed [COEF_WIDTH-1:0] coef [FIR_DEPTH];
  logic [AW-1:0]                wp   [NUM_CH];
  logic [AW-1:0]                rd_ptr;
  logic [CNT_W-1:0]             tap_cnt;
  logic [CH_W-1:0]              ch_q;
  logic signed [ACC_W-1:0]      acc;
  logic                         accept, ch_ok, mac_done, mac_clr, mul_ld, acc_add;
  round_t                       rs;
  logic                         unused_bits;

  assign bus.o_din_ready = i_en && i_rst_n && (state_q == IDLE);
  assign accept   = bus.o_din_ready && bus.i_din_valid;
  assign ch_ok    = int'(bus.iv_din_ch) < NUM_CH;
  assign mac_done = (state_q == MAC) && (tap_cnt == CNT_W'(FIR_DEPTH));
  assign mac_clr  = accept && ch_ok;
  // Product register lags the tap counter by one, so accumulation trails by one cycle.
  assign mul_ld   = i_en && (state_q == MAC) && (tap_cnt < CNT_W'(FIR_DEPTH));
  assign acc_add  = i_en && (state_q == MAC) && (tap_cnt != '0);
  assign o_busy   = (state_q != IDLE);
  assign rs       = round_sat(RS_ACC_W'(acc), COEF_FRAC, DATA_WIDTH);
  assign unused_bits = ^rs.val[RS_VAL_W-1:DATA_WIDTH];

  fir_mac #(.A_W(DATA_WIDTH), .B_W(COEF_WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .en      (i_en),
    .clr     (mac_clr),
    .mul_ld  (mul_ld),
    .acc_add (acc_add),
    .a       (line[ch_q][rd_ptr]),
    .b       (coef[tap_cnt[AW-1:0]]),
    .acc     (acc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_en) begin
      case (state_q)
        IDLE:    if (accept && ch_ok) state_d = MAC;
        MAC:     if (mac_done) state_d = ROUND;
        ROUND:   state_d = OUT;
        OUT:     if (bus.i_dout_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wp[c] <= '0;
        for (int k = 0; k < FIR_DEPTH; k++) line[c][k] <= '0;
      end
      for (int k = 0; k < FIR_DEPTH; k++) coef[k] <= '0;
      rd_ptr           <= '0;
      tap_cnt          <= '0;
      ch_q             <= '0;
      o_sat            <= 1'b0;
      bus.ov_dout      <= '0;
      bus.ov_dout_ch   <= '0;
      bus.o_dout_valid <= 1'b0;
    end else if (i_en) begin
      if (i_coef_we && (state_q == IDLE) && (int'(iv_coef_addr) < FIR_DEPTH))
        coef[iv_coef_addr] <= iv_coef_data;
      if (i_sat_clr) o_sat <= 1'b0;
      case (state_q)
        IDLE: if (accept && ch_ok) begin
          line[bus.iv_din_ch][wp[bus.iv_din_ch]] <= bus.iv_din;
          ch_q    <= bus.iv_din_ch;
          rd_ptr  <= wp[bus.iv_din_ch];
          tap_cnt <= '0;
        end
        MAC: begin
          tap_cnt <= tap_cnt + CNT_W'(1);
          rd_ptr  <= (rd_ptr == '0) ? AW'(FIR_DEPTH - 1) : rd_ptr - AW'(1);
          if (mac_done)
            wp[ch_q] <= (wp[ch_q] == AW'(FIR_DEPTH - 1)) ? '0 : wp[ch_q] + AW'(1);
        end
        ROUND: begin
          bus.ov_dout      <= rs.val[DATA_WIDTH-1:0];
          bus.ov_dout_ch   <= ch_q;
          bus.o_dout_valid <= 1'b1;
          if (rs.sat) o_sat <= 1'b1;
        end
        OUT: if (bus.i_dout_ready) bus.o_dout_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fir_mc_serial.md
Name: fir_mc_serial

Overview:
Multi-channel, time-multiplexed FIR filter. It is the area-reduced successor to the fully parallel tap-chain filter.
- One shared multiply-accumulate unit services NUM_CH independent channels, each with its own circular delay line and a common runtime-loadable coefficient bank.
- Valid/ready handshakes on both sides let it sit between a sample source (ADC/I2S deserialiser) and a downstream mixer or serialiser.
- Output is rounded and saturated.

Parameters:
- DATA_WIDTH, 24: sample width, signed two's complement.
- COEF_WIDTH, 24: coefficient width, signed.
- COEF_FRAC, 23: fractional bits in a coefficient (Q1.23 by default); must be >= 1.
- FIR_DEPTH, 32: taps per channel; must be >= 2.
- NUM_CH, 2: channel count; must be >= 1.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_en, in, 1: global enable. Low freezes the FSM and forces o_din_ready low.
- iv_din, in, DATA_WIDTH: input sample.
- iv_din_ch, in, CH_W: input channel tag, where CH_W = max(1, clog2(NUM_CH)).
- i_din_valid, in, 1: input sample valid.
- o_din_ready, out, 1: block can accept a sample.
- iv_coef_addr, in, clog2(FIR_DEPTH): coefficient index.
- iv_coef_data, in, COEF_WIDTH: coefficient value.
- i_coef_we, in, 1: coefficient write strobe.
- ov_dout, out, DATA_WIDTH: filtered sample.
- ov_dout_ch, out, CH_W: channel tag of ov_dout.
- o_dout_valid, out, 1: output valid.
- i_dout_ready, in, 1: downstream accepts output.
- i_sat_clr, in, 1: clears o_sat.
- o_sat, out, 1: sticky saturation flag.
- o_busy, out, 1: FSM not in IDLE.

Behaviour:
Reset:
- While i_rst_n is low: all outputs 0; FSM in IDLE; accumulator 0.
- All delay-line entries, per-channel write pointers and all coefficients are 0.
- Reset mid-operation aborts the current sample; no output is produced for it.

FSM states: IDLE -> MAC -> ROUND -> OUT -> IDLE.
- o_din_ready = i_en && state==IDLE.

IDLE:
- Accept when i_din_valid && o_din_ready (call this cycle 0).
- The sample is written at line[ch][wp[ch]]; the latched channel tag is held.
- If iv_din_ch >= NUM_CH: the sample is consumed and dropped, no output, FSM stays in IDLE.

MAC:
- Runs FIR_DEPTH+1 cycles: a 1-stage registered product pipeline, then accumulate.
- Tap k uses coef[k] * line[ch][(wp[ch]-k) mod FIR_DEPTH], k = 0..FIR_DEPTH-1; pointer wrap is modulo FIR_DEPTH.
- Accumulator width ACC_W = DATA_WIDTH + COEF_WIDTH + clog2(FIR_DEPTH); it never overflows internally.
- wp[ch] advances by 1 (mod FIR_DEPTH) on leaving MAC.

ROUND, one cycle:
- r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, i.e. round half up.
- Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- If clamped, o_sat sets.

OUT:
- o_dout_valid rises at cycle FIR_DEPTH+3.
- ov_dout and ov_dout_ch are held stable until i_dout_ready is high; the transfer then completes and the FSM returns to IDLE next cycle.
- Minimum sample period is FIR_DEPTH+4 cycles.

Coefficient writes:
- Applied only in IDLE; writes while o_busy=1 are ignored, so coefficients never change mid-sample.
- An IDLE write and a sample accept in the same cycle: the write lands first and the new coefficient is used.

o_sat:
- Sticky; cleared by i_sat_clr.
- A set and a clear in the same cycle: set wins.

i_en low:
- Holds every register, including the MAC and OUT states.
- o_dout_valid stays asserted if already asserted.

Decomposition:
- Package fir_pkg holds:
  - the clog2 function and the ACC_W derivation;
  - the FSM state typedef (IDLE, MAC, ROUND, OUT);
  - the round_sat function (acc, COEF_FRAC, DATA_WIDTH) returning the value and the saturation flag.
- One sub-module, fir_mac: registered multiplier plus accumulator with synchronous clear and enable, shared by all channels.
- Delay lines and the coefficient bank live in the top level.

Test Plan:
1. Single-tap gain: coef[0]=0x400000, others 0; ch0 sample 1000 -> ov_dout=500, ov_dout_ch=0, o_dout_valid exactly 35 cycles after accept (FIR_DEPTH=32).
2. Impulse response: coef[0..3]=0x200000; ch0 samples 400,0,0,0,0 -> outputs 100,100,100,100,0. Rounding check: sample 3 with coef[0]=0x200000 -> output 1.
3. Channel isolation: interleave ch0 impulse 800 (coef[0..3]=0x200000) with ch1 zeros -> ch1 outputs all 0, ch0 outputs 200×4 then 0, tags correct; tag 3 with NUM_CH=2 is dropped with no output.
4. Saturation: all coefs 0x7FFFFF, feed 0x7FFFFF repeatedly -> ov_dout=0x7FFFFF and o_sat=1 held until i_sat_clr; feeding 0x800000 -> ov_dout=0x800000.
5. Backpressure and enable: hold i_dout_ready low 10 cycles -> ov_dout, ov_dout_ch and o_dout_valid stable and o_din_ready=0; drop i_en mid-MAC for 5 cycles -> latency stretches by exactly 5.
6. Reset and coefficient hazards: i_rst_n low at MAC cycle 10 -> all outputs 0 and no output for that sample. After reload, an impulse response shows no residue from earlier samples. A coef write during MAC is ignored, confirmed by an unchanged result on the next sample.
